// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with load-use hazard stall, bubble insertion,
// flush/kill squash, hold freeze and bubble/flush event counters.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_*                decode-slot instruction: pc, opaque payload,
//                       sources/destination and their flags
//   flush, kill         squash the decode slot (bubble into EX)
//   hold                freeze every register of the stage
//   id_stall            IF/ID must not advance this cycle
//   out_*               registered EX slot
//   bubble_cnt          load-use bubbles inserted (wrapping)
//   flush_cnt           cycles with flush or kill (wrapping)
module id_ex_pipe_stage #(
    parameter int XLEN = 32,
    parameter int REG_AW = 5,
    parameter int PAYLOAD_W = 160,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD = '0,
    parameter int LU_PENALTY = 1,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [REG_AW-1:0]    in_rs1,
    input  logic [REG_AW-1:0]    in_rs2,
    input  logic                 in_use_rs1,
    input  logic                 in_use_rs2,
    input  logic                 in_fp_rs1,
    input  logic                 in_fp_rs2,
    input  logic [REG_AW-1:0]    in_rd,
    input  logic                 in_fp_rd,
    input  logic                 in_wr_rd,
    input  logic                 in_is_load,
    input  logic                 flush,
    input  logic                 kill,
    input  logic                 hold,
    output logic                 id_stall,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [REG_AW-1:0]    out_rs1,
    output logic [REG_AW-1:0]    out_rs2,
    output logic [REG_AW-1:0]    out_rd,
    output logic                 out_fp_rd,
    output logic                 out_wr_rd,
    output logic                 out_is_load,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } state_t;

    // Remaining extra bubbles after the first one; the first bubble is
    // inserted from RUN, so LU_WAIT counts down from LU_PENALTY-2.
    localparam logic [3:0] PEN_INIT =
        (LU_PENALTY > 1) ? 4'(LU_PENALTY - 2) : 4'd0;
    localparam logic MULTI = (LU_PENALTY > 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] pen_q;
    logic [3:0] pen_d;

    logic squash;
    logic m1;
    logic m2;
    logic hazard;
    logic go_squash;
    logic go_hold;
    logic go_wait;
    logic go_haz;
    logic go_load;
    logic do_bubble;
    logic do_load;
    logic bump_bub;

    assign squash = flush | kill;

    // Integer x0 is hardwired zero and never carries a dependency;
    // FP f0 is an ordinary register.
    assign m1 = in_use_rs1 & (in_rs1 == out_rd) &
                (in_fp_rs1 == out_fp_rd) &
                ~(~out_fp_rd & (out_rd == '0));
    assign m2 = in_use_rs2 & (in_rs2 == out_rd) &
                (in_fp_rs2 == out_fp_rd) &
                ~(~out_fp_rd & (out_rd == '0));

    assign hazard = out_valid & out_is_load & out_wr_rd &
                    in_valid & (m1 | m2);

    // Mutually exclusive priority terms for the edge decision.
    assign go_squash = squash;
    assign go_hold   = ~squash & hold;
    assign go_wait   = ~squash & ~hold & (state_q == LU_WAIT);
    assign go_haz    = ~squash & ~hold & (state_q == RUN) & hazard;
    assign go_load   = ~squash & ~hold & (state_q == RUN) & ~hazard;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pen_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pen_q   <= pen_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pen_d     = pen_q;
        do_bubble = 1'b0;
        do_load   = 1'b0;
        bump_bub  = 1'b0;
        unique case (1'b1)
            go_squash: begin
                state_d   = RUN;
                pen_d     = 4'd0;
                do_bubble = 1'b1;
            end
            go_hold: begin
                state_d = state_q;
            end
            go_wait: begin
                do_bubble = 1'b1;
                bump_bub  = 1'b1;
                if (pen_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    pen_d = pen_q - 4'd1;
                end
            end
            go_haz: begin
                do_bubble = 1'b1;
                bump_bub  = 1'b1;
                if (MULTI) begin
                    state_d = LU_WAIT;
                    pen_d   = PEN_INIT;
                end
            end
            go_load: begin
                do_load = 1'b1;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Output logic: hold does not mask the stall, a squash does.
    always_comb begin
        id_stall = ((hazard & (state_q == RUN)) |
                    (state_q == LU_WAIT)) & ~squash;
    end

    // EX slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_payload <= BUBBLE_PAYLOAD;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_fp_rd   <= 1'b0;
            out_wr_rd   <= 1'b0;
            out_is_load <= 1'b0;
        end else if (do_bubble) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_payload <= BUBBLE_PAYLOAD;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_fp_rd   <= 1'b0;
            out_wr_rd   <= 1'b0;
            out_is_load <= 1'b0;
        end else if (do_load) begin
            out_valid   <= in_valid;
            out_pc      <= in_pc;
            out_payload <= in_payload;
            out_rs1     <= in_rs1;
            out_rs2     <= in_rs2;
            out_rd      <= in_rd;
            out_fp_rd   <= in_fp_rd;
            out_wr_rd   <= in_wr_rd;
            out_is_load <= in_is_load;
        end
    end

    // Event counters; a squash counts even while hold is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (bump_bub) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (squash) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
